// File: rtl/wallace_mac_pipe.sv
// Pipelined Wallace-tree multiply-accumulate unit with valid/ready handshake.
// Signed mode uses modified Baugh-Wooley partial products.
module wallace_mac_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 3,
  parameter int unsigned ACC_W  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned NR     = WIDTH + 1;
  // Registered tree stages ahead of the final (accumulator) stage.
  localparam int unsigned NS     = STAGES - 1;
  localparam int unsigned RIdxW  = $clog2(NR);
  localparam int unsigned AIdxW  = $clog2(WIDTH);
  localparam int unsigned SIdxW  = (NS > 1) ? $clog2(NS) : 1;

  typedef logic [NR-1:0][PW-1:0] rows_t;

  function automatic logic [RIdxW-1:0] ri(input int unsigned x);
    return RIdxW'(x);
  endfunction

  function automatic logic [AIdxW-1:0] ai(input int unsigned x);
    return AIdxW'(x);
  endfunction

  function automatic logic [SIdxW-1:0] si(input int unsigned x);
    return SIdxW'(x);
  endfunction

  function automatic int unsigned next_rows(input int unsigned n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int unsigned count_levels(input int unsigned n0);
    int unsigned n;
    int unsigned cnt;
    n   = n0;
    cnt = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (n > 2) begin
        n   = next_rows(n);
        cnt = cnt + 1;
      end
    end
    return cnt;
  endfunction

  localparam int unsigned Levels = count_levels(NR);

  // First tree level handled by register stage s (s = NS means end of tree).
  function automatic int unsigned lv_bound(input int unsigned s);
    return (Levels * s) / NS;
  endfunction

  // Unsigned: plain AND array. Signed: invert the cross-sign bits and add
  // 2^WIDTH + 2^(2*WIDTH-1) as an extra row.
  function automatic rows_t gen_pp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sgn);
    rows_t            r;
    logic [WIDTH-1:0] xmask;
    logic [WIDTH-1:0] bits;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      xmask = (i == WIDTH - 1) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      bits  = (a & {WIDTH{b[ai(i)]}}) ^ (sgn ? xmask : '0);
      r[ri(i)] = PW'(bits) << i;
    end
    if (sgn) begin
      r[ri(NR - 1)] = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
    end
    return r;
  endfunction

  // One level of 3:2 compression over the first n live rows; result is packed
  // into the low slots, every slot above the new row count is zero.
  function automatic rows_t csa_level(input rows_t r, input int unsigned n);
    rows_t       o;
    int unsigned g;
    o = '0;
    g = n / 3;
    for (int unsigned k = 0; k < NR / 3; k++) begin
      if (k < g) begin
        o[ri(2*k)]   = r[ri(3*k)] ^ r[ri(3*k+1)] ^ r[ri(3*k+2)];
        o[ri(2*k+1)] = ((r[ri(3*k)] & r[ri(3*k+1)]) | (r[ri(3*k)] & r[ri(3*k+2)]) |
                        (r[ri(3*k+1)] & r[ri(3*k+2)])) << 1;
      end
    end
    for (int unsigned k = 0; k < 2; k++) begin
      if (k < n % 3) begin
        o[ri(2*g+k)] = r[ri(3*g+k)];
      end
    end
    return o;
  endfunction

  function automatic rows_t apply_levels(input rows_t r, input int unsigned lo,
                                         input int unsigned hi);
    rows_t       o;
    int unsigned n;
    o = r;
    n = NR;
    for (int unsigned lv = 0; lv < Levels; lv++) begin
      if (lv >= lo && lv < hi) begin
        o = csa_level(o, n);
      end
      n = next_rows(n);
    end
    return o;
  endfunction

  rows_t            rows_q [NS];
  rows_t            rows_d [NS];
  logic [NS-1:0]    vld_q, vld_d;
  logic [NS-1:0]    sgn_q, sgn_d;
  logic [NS-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             advance;
  logic             accept;
  rows_t            fin_rows;
  logic [PW-1:0]    product;
  logic [ACC_W-1:0] prod_ext;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Final stage: remaining tree levels, carry-propagate add, extension.
  always_comb begin
    fin_rows = apply_levels(rows_q[si(NS - 1)], lv_bound(NS - 1), Levels);
    // Only two rows survive the tree; the rest are constant zero.
    product  = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      product = product + fin_rows[ri(k)];
    end
    prod_ext = ACC_W'(product);
    if (sgn_q[NS-1] && product[PW-1]) begin
      prod_ext = prod_ext | ~(ACC_W'({PW{1'b1}}));
    end
  end

  always_comb begin
    for (int unsigned s = 0; s < NS; s++) begin
      rows_d[si(s)] = rows_q[si(s)];
    end
    vld_d       = vld_q;
    sgn_d       = sgn_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (advance) begin
      rows_d[si(0)] = gen_pp(in_a, in_b, in_signed);
      vld_d[0]      = accept;
      sgn_d[0]      = in_signed;
      acc_d[0]      = in_acc;
      for (int unsigned s = 1; s < NS; s++) begin
        rows_d[si(s)] = apply_levels(rows_q[si(s - 1)], lv_bound(s - 1), lv_bound(s));
        vld_d[si(s)]  = vld_q[si(s - 1)];
        sgn_d[si(s)]  = sgn_q[si(s - 1)];
        acc_d[si(s)]  = acc_q[si(s - 1)];
      end
      out_valid_d = vld_q[NS-1];
      if (vld_q[NS-1]) begin
        out_data_d = acc_q[NS-1] ? out_data_q + prod_ext : prod_ext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q      <= '{default: '0};
      vld_q       <= '0;
      sgn_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rows_q      <= rows_d;
      vld_q       <= vld_d;
      sgn_q       <= sgn_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: doc/wallace_mac_pipe.md
# wallace_mac_pipe

Parametrised, pipelined Wallace-tree multiply-accumulate unit, the next-generation replacement for the fixed 4x4 combinational multiplier. It accepts WIDTH x WIDTH operands in signed or unsigned mode through a valid/ready handshake and reduces the partial products across a configurable number of register stages. Its final stage either loads the product into an ACC_W-bit accumulator or adds the product to it. It sits behind the tile's input decode and drives result data onto the output bus.

## Interface
- WIDTH, 8: operand width in bits, from 4 to 16.
- STAGES, 3: pipeline register stages, from 2 to 4. This is also the accept-to-valid latency.
- ACC_W, 20: accumulator and result width. Must be at least 2*WIDTH.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the block can accept an operation this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned operands.
- in_acc  in  1  1 = add the product to the accumulator; 0 = load the product into the accumulator.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  the consumer accepts the result this cycle.
- out_data  out  ACC_W  accumulator value after this operation.

## Operation
- An operation is accepted when in_valid && in_ready.
- Stage 1 registers the partial products, with sign handling applied when in_signed=1. Sign handling uses Baugh-Wooley or equivalent correction and must be exact for all operand pairs.
- Stages 2 to STAGES-1 register the outputs of the 3:2 compressor tree levels.
  - When STAGES=2, the whole tree sits between stage 1 and the final stage.
- The final stage contains the carry-propagate adder and the accumulator. Product width is 2*WIDTH. The product is extended to ACC_W bits:
  - sign-extended when in_signed=1;
  - zero-extended when in_signed=0.
- The accumulator is the out_data register itself. When the final stage loads:
  - in_acc=0: out_data <= ext(product);
  - in_acc=1: out_data <= out_data + ext(product).
- Accumulation is modulo 2^ACC_W. No saturation and no overflow flag.
- in_signed and in_acc travel down the pipe with their operands.
- The pipeline is globally stalled:
  - advance = !out_valid || out_ready;
  - in_ready = advance, and is forced to 0 while rst=1;
  - when advance=0, every stage register, every valid bit and out_data hold their values.
- Results come out in acceptance order. No operation is dropped or duplicated.
- The accumulator chain continues across consumed results. A later in_acc=1 operation adds to the last value produced, whether or not that value has been read.

## Timing
- Reset values: all stage valid bits 0, out_valid 0, out_data 0. in_ready is 0 while rst is high and 1 in the first cycle after release. Stage data registers may stay unreset but must never be visible.
- Latency: an operation accepted at edge N produces out_valid=1 after edge N+STAGES-1, i.e. it is visible in the cycle following edge N+STAGES-1. This assumes no stall.
- Throughput: one operation per cycle while out_ready=1.
- Simultaneous events:
  - When out_valid && out_ready and the last stage is valid in the same cycle, the new result replaces the old one with no bubble.
  - When out_ready=0 with out_valid=1, the pipe holds up to STAGES operations. in_ready then deasserts combinationally in the same cycle.
- A back-to-back dependent accumulate, i.e. in_acc=1 on consecutive accepts, needs no bubble, because the accumulation happens in the final stage.
- Reset asserted mid-operation clears every in-flight operation and the accumulator immediately. No stale out_valid may appear after release.
- out_data and out_valid remain stable while out_valid=1 and out_ready=0.

## Test plan
- Unsigned max: WIDTH=8, STAGES=3, ACC_W=20, in_a=255, in_b=255, in_signed=0, in_acc=0.
  - Expect out_data=0x0FE01 with out_valid asserted 3 cycles after accept.
- Signed corners, loads, out_ready=1:
  - -128*-128 -> 0x04000;
  - -1*1 -> 0xFFFFF;
  - 127*-128 -> 0xFC080.
- MAC chain, back-to-back, out_ready=1:
  - load 10*10 -> 100;
  - acc unsigned 3*4 -> 112;
  - acc signed -2*50 -> 12.
- Accumulator wrap: load 255*255 unsigned, then 16 consecutive acc 255*255.
  - Expect final out_data=0x0DE11, i.e. 1105425 mod 2^20.
- Backpressure: stream 6 unsigned operations (k, k+1) for k=1..6 with out_ready=0 from the cycle the first result appears, held for 5 cycles.
  - in_ready must drop once 3 operations are held.
  - out_data must stay stable during the stall.
  - After release the results must arrive in order with no loss: 2, 6, 12, 20, 30, 42.
- Reset mid-stream: assert rst for 1 cycle with 3 operations in flight.
  - out_valid=0 and out_data=0 immediately.
  - No result emerges afterward.
  - The next acc 2*3 yields 6, because the accumulator restarts from 0.
